// File: rtl/fifo_ctrl_6x8.sv
// Pointer, occupancy and flag controller that turns the 64x8 memory into a FIFO.
// Memory strobes are combinational accepts; pointers, occupancy, data_valid and error are registered.
module fifo_ctrl_6x8 #(
  parameter int MAIN_SIZE = 6,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] data_push,
  input  logic [MAIN_SIZE:0]   umbral_alto,
  input  logic [MAIN_SIZE:0]   umbral_bajo,
  output logic                 write,
  output logic                 read,
  output logic [MAIN_SIZE-1:0] wr_ptr,
  output logic [MAIN_SIZE-1:0] rd_ptr,
  output logic [DATA_SIZE-1:0] data_in,
  output logic                 data_valid,
  output logic [MAIN_SIZE:0]   occupancy,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_error
);

  localparam int               DEPTH   = 2**MAIN_SIZE;
  localparam logic [MAIN_SIZE:0] DEPTH_V = (MAIN_SIZE+1)'(DEPTH);

  logic push_ok;
  logic pop_ok;
  logic reject;

  always_comb begin
    push_ok = push & ~fifo_full;
    pop_ok  = pop & ~fifo_empty;
    reject  = (push & fifo_full) | (pop & fifo_empty);
  end

  // Strobes are gated by reset so a request during reset never reaches the memory.
  assign write   = reset & push_ok;
  assign read    = reset & pop_ok;
  assign data_in = data_push;

  assign fifo_full    = (occupancy == DEPTH_V);
  assign fifo_empty   = (occupancy == '0);
  assign almost_full  = (occupancy >= umbral_alto);
  assign almost_empty = (occupancy <= umbral_bajo);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      data_valid <= 1'b0;
      fifo_error <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + MAIN_SIZE'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + MAIN_SIZE'(1);
      case ({push_ok, pop_ok})
        2'b10:   occupancy <= occupancy + (MAIN_SIZE+1)'(1);
        2'b01:   occupancy <= occupancy - (MAIN_SIZE+1)'(1);
        default: occupancy <= occupancy;
      endcase
      data_valid <= pop_ok;
      if (reject) fifo_error <= 1'b1;
    end
  end

endmodule
